// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave exposing a byte register bank with auto-incrementing pointer,
// repeated START support, a registered host read port and a write-notification strobe.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk_50,
    input  logic             reset,
    inout  wire              sda,
    input  logic             scl,
    input  logic [PTR_W-1:0] host_addr,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);
    typedef enum logic [3:0] {IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;

    state_t           state_q, state_d;
    logic [1:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic             scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic             sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d, host_rdata_q, host_rdata_d;
    logic             scl_s, sda_s, scl_rise, scl_fall, start, stop, load;
    logic [7:0]       byte_in;

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_in  = {shift_q[6:0], sda_s};

    assign sda        = sda_oe_q ? 1'b0 : 1'bz;
    assign host_rdata = host_rdata_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

    always_comb begin
        scl_sync_d   = {scl_sync_q[0], scl};
        sda_sync_d   = {sda_sync_q[0], sda};
        scl_prev_d   = scl_s;
        sda_prev_d   = sda_s;
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        regs_d       = regs_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        host_rdata_d = regs_q[host_addr];
        load         = 1'b0;
        if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start) begin
            state_d  = DEV_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (scl_rise) begin
            if (state_q inside {DEV_ADDR, PTR, WR_DATA}) begin
                shift_d = byte_in;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    if (state_q == DEV_ADDR) begin
                        state_d = (byte_in[7:1] == SLAVE_ADDR) ? DEV_ACK : IDLE;
                        busy_d  = (byte_in[7:1] == SLAVE_ADDR);
                    end else if (state_q == PTR) begin
                        // Out-of-range pointer: drop to IDLE so the ACK slot is left released (NACK)
                        state_d = ({1'b0, byte_in} < 9'(NUM_REGS)) ? PTR_ACK : IDLE;
                        ptr_d   = ({1'b0, byte_in} < 9'(NUM_REGS)) ? byte_in[PTR_W-1:0] : ptr_q;
                    end else begin
                        regs_d[ptr_q] = byte_in;
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = byte_in;
                        ptr_d         = ptr_q + 1'b1;
                        state_d       = WR_ACK;
                    end
                end
            end else if (state_q == RD_DATA) begin
                cnt_d = cnt_q + 4'd1;
            end else if (state_q == RD_ACK) begin
                shift_d[0] = sda_s;
                cnt_d      = 4'd1;
            end
        end else if (scl_fall) begin
            // ACK states: first fall starts the ACK bit, second fall ends it
            if (state_q inside {DEV_ACK, PTR_ACK, WR_ACK}) begin
                if (cnt_q == 4'd8) begin
                    sda_oe_d = 1'b1;
                    cnt_d    = 4'd9;
                end else begin
                    sda_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = (state_q == DEV_ACK) ? PTR : WR_DATA;
                    load     = (state_q == DEV_ACK) && shift_q[0];
                end
            end else if (state_q == RD_DATA) begin
                if (cnt_q == 4'd8) begin
                    sda_oe_d = 1'b0;
                    ptr_d    = ptr_q + 1'b1;
                    cnt_d    = '0;
                    state_d  = RD_ACK;
                end else if (cnt_q != 4'd0) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    sda_oe_d = ~shift_q[6];
                end
            end else if (state_q == RD_ACK && cnt_q == 4'd1) begin
                state_d = shift_q[0] ? IDLE : RD_DATA;
                load    = ~shift_q[0];
            end
        end
        if (load) begin
            state_d  = RD_DATA;
            shift_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            scl_sync_q   <= 2'b11;
            sda_sync_q   <= 2'b11;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            ptr_q        <= '0;
            regs_q       <= '{default: 8'h00};
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            host_rdata_q <= '0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            regs_q       <= regs_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bus-master stimulus with a queued scoreboard for ACK bits,
// read bytes and write strobes, plus direct host-port and reset checks.
module tb_i2c_slave_regfile;
    localparam int H = 200;
    localparam int Q = 40;

    typedef struct {string nm; int v;} exp_t;
    typedef struct {int a; int d;} wr_t;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_rdata, wr_data;
    logic [3:0] wr_addr;
    logic       wr_strobe, busy;
    wire        sda;

    exp_t exp_q[$];
    int   obs_q[$];
    wr_t  wr_q[$];
    exp_t e;
    wr_t  w;
    int   o;
    int   n_tests = 0;
    int   n_fail = 0;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #10 clk_50 = ~clk_50;

    i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(16)) dut (
        .clk_50(clk_50), .reset(reset), .sda(sda), .scl(scl), .host_addr(host_addr),
        .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    function automatic void check(string nm, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk_50) begin
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check("bus_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.nm, o, e.v);
            end
        end
        if (wr_strobe) begin
            check("wr_expected", int'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("wr_addr", int'(wr_addr), w.a);
                check("wr_data", int'(wr_data), w.d);
            end
        end
    end

    task automatic bitw(input logic b);
        #Q m_low = ~b;
        #(H-Q) scl = 1'b1;
        #H scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        #H scl = 1'b1;
        #H m_low = 1'b1;
        #H scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q m_low = 1'b1;
        #(H-Q) scl = 1'b1;
        #H m_low = 1'b0;
        #H;
    endtask

    // exp_bit: 0 = slave must ACK, 1 = slave must leave sda released
    task automatic wb(input logic [7:0] b, input logic exp_bit);
        logic a;
        exp_q.push_back('{nm: "ack", v: int'(exp_bit)});
        for (int i = 7; i >= 0; i--) bitw(b[i]);
        #Q m_low = 1'b0;
        #(H-Q) scl = 1'b1;
        #(H/2) a = sda;
        #(H/2) scl = 1'b0;
        obs_q.push_back(int'(a));
    endtask

    task automatic rb(input logic nack, input int exp_byte);
        logic [7:0] b;
        b = '0;
        exp_q.push_back('{nm: "rd_byte", v: exp_byte});
        m_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #H scl = 1'b1;
            #(H/2) b = {b[6:0], sda};
            #(H/2) scl = 1'b0;
        end
        obs_q.push_back(int'(b));
        #Q m_low = ~nack;
        #(H-Q) scl = 1'b1;
        #H scl = 1'b0;
        #Q m_low = 1'b0;
        #(H-Q);
    endtask

    task automatic hread(input int a, input int exp);
        host_addr = 4'(a);
        repeat (2) @(negedge clk_50);
        check("host_rdata", int'(host_rdata), exp);
    endtask

    initial begin
        #60;
        check("rst_host_rdata", int'(host_rdata), 0);
        check("rst_wr_strobe", int'(wr_strobe), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sda", int'(sda), 1);
        #40 reset = 1'b1;
        #200;

        wr_q.push_back('{a: 3, d: 'h11});
        wr_q.push_back('{a: 4, d: 'h22});
        i2c_start(); wb(8'hA0, 0); wb(8'h03, 0); wb(8'h11, 0); wb(8'h22, 0);
        check("busy_in_write", int'(busy), 1);
        i2c_stop();
        check("busy_after_stop", int'(busy), 0);
        hread(3, 'h11); hread(4, 'h22);

        wr_q.push_back('{a: 15, d: 'hAA});
        wr_q.push_back('{a: 0, d: 'hBB});
        wr_q.push_back('{a: 1, d: 'hCC});
        i2c_start(); wb(8'hA0, 0); wb(8'h0F, 0); wb(8'hAA, 0); wb(8'hBB, 0); wb(8'hCC, 0);
        i2c_stop();
        hread(15, 'hAA); hread(0, 'hBB); hread(1, 'hCC);

        i2c_start(); wb(8'hA0, 0); wb(8'h03, 0);
        i2c_start(); wb(8'hA1, 0); rb(0, 'h11); rb(1, 'h22);
        check("busy_in_read", int'(busy), 1);
        i2c_stop();
        check("busy_read_stop", int'(busy), 0);

        i2c_start(); wb(8'hA2, 1);
        check("busy_mismatch", int'(busy), 0);
        i2c_stop();
        hread(3, 'h11);
        i2c_start(); wb(8'hA0, 0); wb(8'h20, 1); wb(8'h77, 1);
        i2c_stop();
        check("busy_badptr_stop", int'(busy), 0);
        hread(0, 'hBB); hread(4, 'h22);

        i2c_start(); wb(8'hA0, 0); wb(8'h05, 0);
        bitw(1); bitw(0); bitw(1); bitw(0);
        m_low = 1'b0;
        #20 reset = 1'b0;
        #1;
        check("midrst_sda", int'(sda), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_wr_addr", int'(wr_addr), 0);
        check("midrst_wr_data", int'(wr_data), 0);
        check("midrst_host_rdata", int'(host_rdata), 0);
        #19 scl = 1'b1;
        #100 reset = 1'b1;
        #200;
        hread(5, 0); hread(3, 0);

        wr_q.push_back('{a: 5, d: 'h5A});
        i2c_start(); wb(8'hA0, 0); wb(8'h05, 0); wb(8'h5A, 0);
        i2c_stop();
        hread(5, 'h5A);
        wr_q.push_back('{a: 3, d: 'h11});
        i2c_start(); wb(8'hA0, 0); wb(8'h03, 0); wb(8'h11, 0);
        i2c_stop();
        hread(3, 'h11);

        wr_q.push_back('{a: 3, d: 'h55});
        fork
            begin
                i2c_start(); wb(8'hA0, 0); wb(8'h03, 0); wb(8'h55, 0);
                i2c_stop();
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 5000 && !seen; i++) begin
                    @(negedge clk_50);
                    if (wr_strobe) seen = 1'b1;
                end
                check("collide_strobe_seen", int'(seen), 1);
                if (seen) begin
                    check("collide_old", int'(host_rdata), 'h11);
                    @(negedge clk_50);
                    check("collide_new", int'(host_rdata), 'h55);
                end
            end
        join
        hread(3, 'h55);

        repeat (40) @(negedge clk_50);
        check("bus_queue_drained", exp_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C slave that exposes a bank of byte-wide registers to an external I2C master. It supports a configurable 7-bit device address, pointer-based multi-byte writes and reads with auto-increment and wrap, and repeated START. It also provides a host-side read port and a write-notification strobe. It replaces the fixed-function `i2c_slave` wherever on-chip logic must share configuration/status registers with an I2C master.

## Interface
Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address matched after START
- NUM_REGS, 16, register count; power of two, 2..256
- PTR_W, $clog2(NUM_REGS), pointer width (derived, do not override)

Ports:
- clk_50  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- sda  inout  1  open-drain data; block drives 0 or Z only
- scl  input  1  I2C clock from master (no clock stretching)
- host_addr  input  PTR_W  host read address
- host_rdata  output  8  registered regs[host_addr]
- wr_strobe  output  1  one-cycle pulse per byte written by I2C
- wr_addr  output  PTR_W  register index of last I2C write
- wr_data  output  8  data of last I2C write
- busy  output  1  high from addressed START until STOP/abort

## Operation
- scl and sda pass through a 2-flop synchroniser on clk_50, then a 1-flop edge detector.
- START: synced sda falls while scl is high. STOP: synced sda rises while scl is high.
- Bits are sampled on scl rising edges; sda_oe changes only after scl falling edges.
- States: IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START from any state -> DEV_ADDR with the bit counter cleared. This covers repeated START.
- STOP from any state -> IDLE, sda released, busy=0.
- DEV_ADDR: shift in 8 bits (MSB first).
  - [7:1]!=SLAVE_ADDR -> IDLE, no ACK. The block ignores the bus until the next START.
  - On match -> DEV_ACK: drive sda low for one scl period; busy=1.
  - After ACK, R/W=0 -> PTR; R/W=1 -> RD_DATA.
- PTR: shift in 8 bits.
  - Value < NUM_REGS -> ptr := value, ACK, then WR_DATA.
  - Value >= NUM_REGS -> NACK (sda released), then IDLE. ptr is unchanged.
- WR_DATA: shift in 8 bits.
  - regs[ptr] := byte; wr_strobe=1 for one clk_50; wr_addr=ptr; wr_data=byte.
  - Then ptr := ptr+1 mod NUM_REGS, ACK, and loop to WR_DATA.
- RD_DATA: shift out regs[ptr] MSB first, latched at the falling scl edge that enters RD_DATA. Then ptr := ptr+1 mod NUM_REGS.
  - RD_ACK: sample master bit on scl rise. ACK (0) -> RD_DATA. NACK (1) -> IDLE, awaiting STOP.
- Reset values:
  - regs all 0x00, ptr=0, state IDLE, sda released
  - host_rdata=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0
- Reset asserted mid-transfer: the block releases sda immediately (asynchronously) and the partial byte is discarded. After reset deasserts, the block waits for a fresh START.
- Host/I2C collision: a host read and an I2C write to the same index in the same clk_50 cycle return the pre-write value; the new value appears on the next cycle.

## Timing
- Input path latency is 3 clk_50 cycles (2 sync + 1 edge detect).
- sda drive/release completes ≤4 clk_50 cycles after scl falls.
- Legal scl high and low phases are each ≥8 clk_50 cycles (≤ ~3 MHz scl). Faster scl is unsupported.
- wr_strobe asserts 1 clk_50 after the rising edge that samples the 8th data bit. It asserts before the ACK is driven.
- host_rdata has 1-cycle latency from host_addr.
- ptr increments on the same cycle as the write strobe, or on the 8th read bit's falling edge.

## Test plan
- Write burst: START, 0xA0, 0x03, 0x11, 0x22, STOP.
  - Expect ACK on all 4 bytes.
  - regs[3]=0x11 and regs[4]=0x22.
  - wr_strobe pulses twice, with (3,0x11) then (4,0x22).
- Wrap: START, 0xA0, 0x0F, 0xAA, 0xBB, 0xCC, STOP.
  - Expect regs[15]=0xAA, regs[0]=0xBB, regs[1]=0xCC.
- Repeated-START read: after the write burst, START, 0xA0, 0x03, rSTART, 0xA1, read 2 bytes (ACK then NACK), STOP.
  - Expect sda bytes 0x11, 0x22.
  - busy falls at STOP.
- Address mismatch and bad pointer:
  - START, 0xA2 -> no ACK, busy stays 0, and no register changes.
  - START, 0xA0, 0x20 -> ACK then NACK, and the next data byte is ignored.
- Reset mid-byte: assert reset after 4 data bits of a write to regs[5].
  - Expect sda=Z immediately and all outputs at reset values.
  - regs[5]=0x00, and a subsequent clean transaction is ACKed.
- Host port: with host_addr=3, host_rdata=0x11 one cycle later. A simultaneous I2C write of 0x55 to index 3 shows 0x11 first, then 0x55.
